// File: rtl/intr_ctrl_pkg.sv
// Shared constants and helpers for the eight-line interrupt controller.
package intr_pkg;
  localparam int NUM_IRQ = 8;
  localparam int PC_W = 10;
  localparam logic [PC_W-1:0] VEC_BASE = 10'h3F0;

  // Isolates the lowest set bit (highest priority), or returns 0.
  function automatic logic [NUM_IRQ-1:0] lsb_onehot(input logic [NUM_IRQ-1:0] x);
    return x & (~x + NUM_IRQ'(1));
  endfunction

  function automatic logic [2:0] onehot_index(input logic [NUM_IRQ-1:0] x);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (x[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/intr_ctrl_if.sv
// Control-unit link: call/return strobes in, priority selections and vector out.
// s_intr qualifies s_call_intr/s_return_intr for one cycle; the selection outputs
// are always valid and depend only on registered state, so there is no ready path.
interface intr_ctrl_if;
  import intr_pkg::*;
  logic                s_intr;
  logic [NUM_IRQ-1:0]  s_call_intr;
  logic [NUM_IRQ-1:0]  s_return_intr;
  logic [NUM_IRQ-1:0]  min_bit_s;
  logic [NUM_IRQ-1:0]  min_bit_a;
  logic [PC_W-1:0]     vector;

  modport master (
    output s_intr, s_call_intr, s_return_intr,
    input  min_bit_s, min_bit_a, vector
  );

  modport slave (
    input  s_intr, s_call_intr, s_return_intr,
    output min_bit_s, min_bit_a, vector
  );
endinterface

// File: rtl/intr_ctrl_irq_edge_sync.sv
// Two-flop synchroniser for one raw request line with a rising-edge pulse.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic pulse
);
  logic sync1, sync2, prev;

  // During reset the chain tracks the line with prev equal to sync2, so
  // in-flight requests are dropped and a line held high is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync1;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending/in-service tracking with fixed lowest-index priority.
module intr_ctrl
  import intr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ie_we,
  input  logic [NUM_IRQ-1:0] ie_d,
  input  logic               ovr_clr,
  intr_ctrl_if.slave         bus,
  output logic [NUM_IRQ-1:0] ie_q,
  output logic [NUM_IRQ-1:0] overrun,
  output logic               err
);
  logic [NUM_IRQ-1:0] edge_pulse;
  logic [NUM_IRQ-1:0] pending, in_service, ie, ovr;
  logic               err_q;

  logic [NUM_IRQ-1:0] acc, ret, bad_ret;
  logic [NUM_IRQ-1:0] pending_n, in_service_n, ovr_n;
  logic               err_n;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_edge_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq[i]),
      .pulse (edge_pulse[i])
    );
  end

  always_comb begin
    acc          = bus.s_intr ? bus.s_call_intr : '0;
    ret          = bus.s_intr ? bus.s_return_intr : '0;
    bad_ret      = ret & ~in_service;
    // A fresh edge wins over a same-cycle accept of the same line.
    pending_n    = (pending & ~acc) | edge_pulse;
    ovr_n        = (ovr_clr ? '0 : ovr) | (edge_pulse & pending & ~acc);
    err_n        = err_q | (|bad_ret);
    in_service_n = in_service;
    if (bad_ret == '0) in_service_n = in_service_n & ~ret;
    in_service_n = in_service_n | acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      in_service <= '0;
      ie         <= '0;
      ovr        <= '0;
      err_q      <= 1'b0;
    end else begin
      pending    <= pending_n;
      in_service <= in_service_n;
      ovr        <= ovr_n;
      err_q      <= err_n;
      if (ie_we) ie <= ie_d;
    end
  end

  assign bus.min_bit_s = lsb_onehot(pending & ie);
  assign bus.min_bit_a = lsb_onehot(in_service);
  assign bus.vector    = VEC_BASE + PC_W'(onehot_index(bus.min_bit_s));
  assign ie_q          = ie;
  assign overrun       = ovr;
  assign err           = err_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed scoreboard bench for intr_ctrl covering latency, priority, nesting, masking and sticky flags.
module tb_intr_ctrl;
  import intr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq, ie_d, ie_q, overrun;
  logic       ie_we, ovr_clr, err;

  intr_ctrl_if bus ();

  intr_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .ie_we   (ie_we),
    .ie_d    (ie_d),
    .ovr_clr (ovr_clr),
    .bus     (bus),
    .ie_q    (ie_q),
    .overrun (overrun),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  // {min_bit_s, min_bit_a, vector, overrun, err, ie_q}
  logic [42:0] exp_q[$];
  logic [7:0]  ie_m, ovr_m;
  logic        err_m;

  function automatic logic [9:0] vec_of(input logic [7:0] ms);
    logic [7:0] one;
    logic [9:0] v;
    one = 8'h01;
    v   = 10'h3F0;
    for (int i = 0; i < 8; i++) begin
      if (ms == (one << i)) v = 10'h3F0 + 10'(i);
    end
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [7:0] ms, input logic [7:0] ma);
    exp_q.push_back({ms, ma, vec_of(ms), ovr_m, err_m, ie_m});
  endtask

  task automatic compare_out(input string tag);
    logic [42:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, ".min_s"}, 16'(bus.min_bit_s), 16'(e[42:35]));
      check_val({tag, ".min_a"}, 16'(bus.min_bit_a), 16'(e[34:27]));
      check_val({tag, ".vector"}, 16'(bus.vector), 16'(e[26:17]));
      check_val({tag, ".overrun"}, 16'(overrun), 16'(e[16:9]));
      check_val({tag, ".err"}, 16'(err), 16'(e[8]));
      check_val({tag, ".ie_q"}, 16'(ie_q), 16'(e[7:0]));
    end
  endtask

  task automatic step_chk(input string tag, input logic [7:0] ms, input logic [7:0] ma);
    expect_out(ms, ma);
    step();
    compare_out(tag);
  endtask

  task automatic set_ie(input string tag, input logic [7:0] v, input logic [7:0] ms,
                        input logic [7:0] ma);
    ie_we = 1'b1;
    ie_d  = v;
    ie_m  = v;
    step_chk(tag, ms, ma);
    ie_we = 1'b0;
  endtask

  task automatic intr_cycle(input string tag, input logic [7:0] call, input logic [7:0] ret,
                            input logic [7:0] ms, input logic [7:0] ma);
    bus.s_intr        = 1'b1;
    bus.s_call_intr   = call;
    bus.s_return_intr = ret;
    step_chk(tag, ms, ma);
    bus.s_intr        = 1'b0;
    bus.s_call_intr   = '0;
    bus.s_return_intr = '0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; ie_we = 1'b0; ie_d = '0; ovr_clr = 1'b0;
    bus.s_intr = 1'b0; bus.s_call_intr = '0; bus.s_return_intr = '0;
    ie_m = '0; ovr_m = '0; err_m = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    step_chk("reset", 8'h00, 8'h00);
    set_ie("ie_ff", 8'hFF, 8'h00, 8'h00);

    // Single request: three-edge latency, accept, return
    irq = 8'h08; step(); step_chk("irq3_lat2", 8'h00, 8'h00);
    step_chk("irq3", 8'h08, 8'h00); irq = '0;
    intr_cycle("acc3", 8'h08, 8'h00, 8'h00, 8'h08);
    intr_cycle("ret3", 8'h00, 8'h08, 8'h00, 8'h00);

    // Simultaneous requests resolve by priority
    irq = 8'h24; step(); step(); step_chk("irq52", 8'h04, 8'h00); irq = '0;
    intr_cycle("acc2", 8'h04, 8'h00, 8'h20, 8'h04);
    intr_cycle("acc5_ret2", 8'h20, 8'h04, 8'h00, 8'h20);
    intr_cycle("ret5", 8'h00, 8'h20, 8'h00, 8'h00);

    // Nesting: level 1 preempts level 4
    irq = 8'h10; step(); step(); step_chk("irq4", 8'h10, 8'h00); irq = '0;
    intr_cycle("acc4", 8'h10, 8'h00, 8'h00, 8'h10);
    irq = 8'h02; step(); step(); step_chk("irq1", 8'h02, 8'h10); irq = '0;
    intr_cycle("acc1", 8'h02, 8'h00, 8'h00, 8'h02);
    intr_cycle("ret1", 8'h00, 8'h02, 8'h00, 8'h10);
    intr_cycle("ret4", 8'h00, 8'h10, 8'h00, 8'h00);

    // Masking keeps pending; enabling exposes it
    set_ie("ie_00", 8'h00, 8'h00, 8'h00);
    irq = 8'h01; step(); step(); step_chk("irq0_masked", 8'h00, 8'h00); irq = '0;
    set_ie("ie_01", 8'h01, 8'h01, 8'h00);
    intr_cycle("acc0", 8'h01, 8'h00, 8'h00, 8'h01);
    intr_cycle("ret0", 8'h00, 8'h01, 8'h00, 8'h00);
    set_ie("ie_ff2", 8'hFF, 8'h00, 8'h00);

    // Overrun on a second edge to a pending line, then clear
    irq = 8'h40; step(); step(); step_chk("irq6", 8'h40, 8'h00); irq = '0;
    step(); step(); step();
    irq = 8'h40; step(); step(); ovr_m = 8'h40;
    step_chk("ovr6", 8'h40, 8'h00); irq = '0;
    ovr_clr = 1'b1; ovr_m = '0; step_chk("ovr_clr", 8'h40, 8'h00); ovr_clr = 1'b0;
    intr_cycle("acc6", 8'h40, 8'h00, 8'h00, 8'h40);
    intr_cycle("ret6", 8'h00, 8'h40, 8'h00, 8'h00);

    // Edge coinciding with accept of the same line: stays pending, no overrun
    irq = 8'h80; step(); step(); step_chk("irq7", 8'h80, 8'h00); irq = '0;
    step(); step(); step();
    irq = 8'h80; step(); step();
    intr_cycle("acc7_edge", 8'h80, 8'h00, 8'h80, 8'h80); irq = '0;
    intr_cycle("ret7", 8'h00, 8'h80, 8'h80, 8'h00);
    intr_cycle("acc7b", 8'h80, 8'h00, 8'h00, 8'h80);
    intr_cycle("ret7b", 8'h00, 8'h80, 8'h00, 8'h00);

    // Return for a level not in service
    err_m = 1'b1;
    intr_cycle("err_ret", 8'h00, 8'h80, 8'h00, 8'h00);

    // Reset mid-operation with lines held high
    irq = 8'h1F; step(); step(); step_chk("irq_1f", 8'h01, 8'h00);
    intr_cycle("acc4b", 8'h10, 8'h00, 8'h01, 8'h10);
    reset = 1'b1; ie_m = '0; ovr_m = '0; err_m = 1'b0;
    step_chk("in_reset", 8'h00, 8'h00);
    step(); step();
    reset = 1'b0;
    step_chk("post_reset", 8'h00, 8'h00);
    set_ie("held_irq", 8'hFF, 8'h00, 8'h00);
    step(); step(); step_chk("held_irq2", 8'h00, 8'h00);
    irq = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
